// File: rtl/life_pkg.sv
// Shared types and helpers for the Game of Life sequencer.
package life_pkg;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    DIR_NONE = 3'd0,
    DIR_L    = 3'd1,
    DIR_R    = 3'd2,
    DIR_U    = 3'd3,
    DIR_D    = 3'd4
  } dir_t;

  // Maps the four buttons to a direction only when exactly one is pressed.
  function automatic dir_t onehot_dir(input logic l, input logic r,
                                      input logic u, input logic d);
    dir_t dir;
    case ({l, r, u, d})
      4'b1000: dir = DIR_L;
      4'b0100: dir = DIR_R;
      4'b0010: dir = DIR_U;
      4'b0001: dir = DIR_D;
      default: dir = DIR_NONE;
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/life_input_edge.sv
// Turns the level board inputs into single-cycle move and confirm events.
import life_pkg::*;

module life_input_edge (
  input  logic clk,
  input  logic reset,
  input  logic leftBtn,
  input  logic rightBtn,
  input  logic upBtn,
  input  logic downBtn,
  input  logic confirmSw,
  output dir_t moveDir,
  output logic confirmPulse
);

  logic [3:0] prevBtn;
  logic       prevConfirm;

  always_ff @(posedge clk) begin
    if (reset) begin
      prevBtn     <= 4'b0000;
      prevConfirm <= 1'b0;
    end else begin
      prevBtn     <= {leftBtn, rightBtn, upBtn, downBtn};
      prevConfirm <= confirmSw;
    end
  end

  // A held button (or any button still down from last cycle) blocks new moves.
  assign moveDir      = (prevBtn == 4'b0000) ? onehot_dir(leftBtn, rightBtn, upBtn, downBtn)
                                             : DIR_NONE;
  assign confirmPulse = confirmSw & ~prevConfirm;

endmodule

// File: rtl/life_game_sequencer.sv
// Central sequencer: game phase, setup cursor, seed strobe and generation tick.
import life_pkg::*;

module life_game_sequencer #(
  parameter int ROWS     = 16,
  parameter int COLS     = 16,
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    left_btn,
  input  logic                    right_btn,
  input  logic                    up_btn,
  input  logic                    down_btn,
  input  logic                    confirm_sw,
  input  logic                    start_sw,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    cursor_en,
  output logic                    seed_write,
  output phase_t                  phase,
  output logic                    gen_step,
  output logic [CNT_W-1:0]        gen_count
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [RW-1:0] MAX_ROW    = RW'(ROWS - 1);
  localparam logic [CW-1:0] MAX_COL    = CW'(COLS - 1);
  localparam logic [RW-1:0] HOME_ROW   = RW'(ROWS / 2);
  localparam logic [CW-1:0] HOME_COL   = CW'(COLS / 2);
  localparam logic [PW-1:0] PRE_RELOAD = PW'(TICK_DIV - 1);

  dir_t          moveDir;
  logic          confirmPulse;
  dir_t          pendingDir;
  dir_t          applyDir;
  logic [RW-1:0] nextRow;
  logic [CW-1:0] nextCol;
  logic [PW-1:0] prescaler;

  life_input_edge u_edge (
    .clk          (clk),
    .reset        (reset),
    .leftBtn      (left_btn),
    .rightBtn     (right_btn),
    .upBtn        (up_btn),
    .downBtn      (down_btn),
    .confirmSw    (confirm_sw),
    .moveDir      (moveDir),
    .confirmPulse (confirmPulse)
  );

  // A move coinciding with confirm is deferred one cycle so the seed lands on
  // the pre-move cursor while seed_write is high. A deferred move can never
  // collide with a new move or confirm event, since both need a quiet cycle.
  always_comb begin
    applyDir = DIR_NONE;
    if (pendingDir != DIR_NONE) applyDir = pendingDir;
    else if (!confirmPulse)     applyDir = moveDir;
  end

  always_comb begin
    nextRow = cursor_row;
    nextCol = cursor_col;
    case (applyDir)
      DIR_L: if (cursor_col != '0)     nextCol = cursor_col - 1'b1;
      DIR_R: if (cursor_col != MAX_COL) nextCol = cursor_col + 1'b1;
      DIR_U: if (cursor_row != '0)     nextRow = cursor_row - 1'b1;
      DIR_D: if (cursor_row != MAX_ROW) nextRow = cursor_row + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= SETUP;
      cursor_row <= HOME_ROW;
      cursor_col <= HOME_COL;
      seed_write <= 1'b0;
      gen_step   <= 1'b0;
      gen_count  <= '0;
      prescaler  <= PRE_RELOAD;
      pendingDir <= DIR_NONE;
    end else begin
      seed_write <= 1'b0;
      gen_step   <= 1'b0;
      case (phase)
        SETUP: begin
          if (start_sw) begin
            phase      <= LOAD;
            pendingDir <= DIR_NONE;
          end else begin
            cursor_row <= nextRow;
            cursor_col <= nextCol;
            seed_write <= confirmPulse;
            pendingDir <= confirmPulse ? moveDir : DIR_NONE;
          end
        end
        LOAD: begin
          phase     <= RUN;
          prescaler <= PRE_RELOAD;
        end
        RUN: begin
          if (prescaler == '0) begin
            gen_step  <= 1'b1;
            prescaler <= PRE_RELOAD;
            if (gen_count != '1) gen_count <= gen_count + 1'b1;
          end else begin
            prescaler <= prescaler - 1'b1;
          end
          if (!start_sw) phase <= PAUSE;
        end
        PAUSE: begin
          if (start_sw) phase <= RUN;
        end
        default: phase <= SETUP;
      endcase
    end
  end

  assign cursor_en = (phase == SETUP);

endmodule

// File: tb/tb_life_game_sequencer.sv
// Directed bench for life_game_sequencer: 8x8 grid, TICK_DIV=4, 2-bit generation counter.
import life_pkg::*;

module tb_life_game_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic left_btn, right_btn, up_btn, down_btn, confirm_sw, start_sw;
  logic [2:0] cursor_row, cursor_col;
  logic       cursor_en, seed_write, gen_step;
  phase_t     phase;
  logic [1:0] gen_count;

  life_game_sequencer #(.ROWS(8), .COLS(8), .TICK_DIV(4), .CNT_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_btn   (left_btn),
    .right_btn  (right_btn),
    .up_btn     (up_btn),
    .down_btn   (down_btn),
    .confirm_sw (confirm_sw),
    .start_sw   (start_sw),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .cursor_en  (cursor_en),
    .seed_write (seed_write),
    .phase      (phase),
    .gen_step   (gen_step),
    .gen_count  (gen_count)
  );

  int total = 0;
  int bad   = 0;

  // Expected {row,col} for each seed_write, expected gen_count for each gen_step.
  logic [5:0] exp_seed_q[$];
  logic [1:0] exp_gen_q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      0: left_btn  = 1'b1;
      1: right_btn = 1'b1;
      2: up_btn    = 1'b1;
      default: down_btn = 1'b1;
    endcase
    tick();
    {left_btn, right_btn, up_btn, down_btn} = 4'b0000;
    tick();
  endtask

  task automatic wait_gen(input int exp_cycles, input string name);
    int  n    = 0;
    bit  seen = 1'b0;
    while (n < 20 && !seen) begin
      tick();
      n++;
      if (gen_step) seen = 1'b1;
    end
    check(name, seen ? n : -1, exp_cycles);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [5:0] es;
    logic [1:0] eg;
    if (seed_write) begin
      if (exp_seed_q.size() == 0) begin
        total++; bad++;
        $display("FAIL seed_unexpected: got seed_write=1 at (%0d,%0d) expected 0", cursor_row, cursor_col);
      end else begin
        es = exp_seed_q.pop_front();
        check("seed_pos", {cursor_row, cursor_col}, es);
      end
    end
    if (gen_step) begin
      if (exp_gen_q.size() == 0) begin
        total++; bad++;
        $display("FAIL gen_unexpected: got gen_step=1 count=%0d expected 0", gen_count);
      end else begin
        eg = exp_gen_q.pop_front();
        check("gen_count_at_step", gen_count, eg);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int exp_cols[5] = '{3, 2, 1, 0, 0};
    reset = 1'b1;
    {left_btn, right_btn, up_btn, down_btn, confirm_sw, start_sw} = 6'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    check("reset_row", cursor_row, 4);
    check("reset_col", cursor_col, 4);
    check("reset_phase", phase, SETUP);
    check("reset_cursor_en", cursor_en, 1);
    check("reset_seed_write", seed_write, 0);
    check("reset_gen_step", gen_step, 0);
    check("reset_gen_count", gen_count, 0);

    // Left taps walk to the edge and clamp.
    for (int i = 0; i < 5; i++) begin
      press(0);
      check("left_col", cursor_col, exp_cols[i]);
    end

    // Held right gives one move only.
    right_btn = 1'b1;
    repeat (10) tick();
    right_btn = 1'b0;
    tick();
    check("held_right_col", cursor_col, 1);

    // Two buttons at once: no move.
    left_btn = 1'b1; up_btn = 1'b1;
    tick();
    left_btn = 1'b0; up_btn = 1'b0;
    tick();
    check("multi_row", cursor_row, 4);
    check("multi_col", cursor_col, 1);

    repeat (3) press(1);
    check("back_home_col", cursor_col, 4);

    // Confirm rise at (4,4), then hold: only one seed_write.
    exp_seed_q.push_back({3'd4, 3'd4});
    confirm_sw = 1'b1;
    repeat (4) tick();
    confirm_sw = 1'b0;
    tick();

    // Confirm together with a down move: seed at pre-move cursor, then move.
    exp_seed_q.push_back({3'd4, 3'd4});
    confirm_sw = 1'b1; down_btn = 1'b1;
    tick();
    check("combo_seed_row", cursor_row, 4);
    tick();
    check("combo_moved_row", cursor_row, 5);
    confirm_sw = 1'b0; down_btn = 1'b0;
    tick();

    // Start in the same cycle as a confirm rise: no seed, go to LOAD then RUN.
    confirm_sw = 1'b1; start_sw = 1'b1;
    tick();
    check("load_phase", phase, LOAD);
    check("load_cursor_en", cursor_en, 0);
    confirm_sw = 1'b0;
    tick();
    check("run_phase", phase, RUN);
    check("run_cursor_en", cursor_en, 0);

    // Generation period of four cycles.
    exp_gen_q.push_back(2'd1);
    wait_gen(4, "first_step_delay");
    exp_gen_q.push_back(2'd2);
    wait_gen(4, "step_period");

    // Pause mid-count and hold.
    tick();
    start_sw = 1'b0;
    tick();
    check("pause_phase", phase, PAUSE);
    repeat (6) tick();
    check("pause_phase_held", phase, PAUSE);
    check("pause_gen_count", gen_count, 2);

    // Resume: remaining count is one before terminal.
    start_sw = 1'b1;
    exp_gen_q.push_back(2'd3);
    wait_gen(3, "resume_step_delay");

    // Counter saturates at 3.
    for (int i = 0; i < 3; i++) begin
      exp_gen_q.push_back(2'd3);
      wait_gen(4, "sat_step_period");
    end
    check("sat_gen_count", gen_count, 3);

    // Reset on the cycle a step would have been issued.
    repeat (3) tick();
    reset = 1'b1; start_sw = 1'b0;
    tick();
    check("midrun_reset_phase", phase, SETUP);
    check("midrun_reset_row", cursor_row, 4);
    check("midrun_reset_col", cursor_col, 4);
    check("midrun_reset_gen_count", gen_count, 0);
    check("midrun_reset_gen_step", gen_step, 0);
    check("midrun_reset_cursor_en", cursor_en, 1);
    reset = 1'b0;
    tick();
    check("post_reset_phase", phase, SETUP);
    check("post_reset_gen_step", gen_step, 0);

    // ---------------- final report ----------------
    tick();
    #1;
    check("seed_queue_drained", exp_seed_q.size(), 0);
    check("gen_queue_drained", exp_gen_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
